// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_sb register file:
//   - default geometry constants (DEF_DW, DEF_AW, DEF_ENTRY)
//   - ra_field(): extracts one read-port address from the packed RA bus
//   - wr_resolve(): write-port priority resolution (port 1 over port 0),
//     shared by the array write logic and the read bypass muxes
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_DW    = 32;
   localparam int DEF_AW    = 5;
   localparam int DEF_ENTRY = 32;

   // Widest address and flattened RA bus the unpack helper supports
   // (up to 4 read ports of up to 32 address bits each).
   localparam int unsigned MAX_AW    = 32;
   localparam int unsigned RA_FLAT_W = 4 * MAX_AW;

   typedef struct packed {
      logic hit;   // some enabled port targets the address
      logic sel1;  // data comes from port 1
   } wr_sel_t;

   // Returns RA field k (aw bits wide), zero-extended to MAX_AW bits.
   function automatic logic [MAX_AW-1:0] ra_field(input logic [RA_FLAT_W-1:0] ra_flat,
                                                  input int unsigned         k,
                                                  input int unsigned         aw);
      logic [MAX_AW-1:0] mask;
      mask = (aw >= MAX_AW) ? '1 : ((MAX_AW'(1) << aw) - MAX_AW'(1));
      return MAX_AW'(ra_flat >> (k * aw)) & mask;
   endfunction

   // Enables are active low; m0/m1 are the per-port address matches.
   function automatic wr_sel_t wr_resolve(input logic wen0_n, input logic m0,
                                          input logic wen1_n, input logic m1);
      wr_sel_t r;
      r.sel1 = !wen1_n && m1;
      r.hit  = r.sel1 || (!wen0_n && m0);
      return r;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bus between the decode/writeback logic (master) and regfile_sb (slave).
//   WEN0/WA0/DI0  write port 0 (enable active low)
//   WEN1/WA1/DI1  write port 1 (enable active low, wins over port 0)
//   RA            packed read addresses, port k at [k*AW +: AW]
//   DOUT          packed read data, port k at [k*DW +: DW]
//   ISSUE/IWA     mark register IWA as pending writeback
//   BUSY          per-read-port pending flag
//   ANY_BUSY      OR of all stored busy bits
// ---------------------------------------------------------------------------
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int DW  = DEF_DW,
   parameter int AW  = DEF_AW,
   parameter int NRD = 2
) ();

   logic              WEN0;
   logic [AW-1:0]     WA0;
   logic [DW-1:0]     DI0;
   logic              WEN1;
   logic [AW-1:0]     WA1;
   logic [DW-1:0]     DI1;
   logic [NRD*AW-1:0] RA;
   logic [NRD*DW-1:0] DOUT;
   logic              ISSUE;
   logic [AW-1:0]     IWA;
   logic [NRD-1:0]    BUSY;
   logic              ANY_BUSY;

   modport master (
      output WEN0, WA0, DI0, WEN1, WA1, DI1, RA, ISSUE, IWA,
      input  DOUT, BUSY, ANY_BUSY
   );

   modport slave (
      input  WEN0, WA0, DI0, WEN1, WA1, DI1, RA, ISSUE, IWA,
      output DOUT, BUSY, ANY_BUSY
   );

endinterface

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of regfile_sb: array mux, masking of register 0
// and out-of-range addresses, optional write bypass, BUSY select.
// Optional feature macro: REGFILE_BYPASS_EN (adds the write-port inputs and
// the bypass muxes).
// Ports:
//   wen0_n/wa0/di0, wen1_n/wa1/di1  current-cycle write ports (bypass only)
//   ra        read address
//   mem       registered array contents
//   busy_vec  registered busy bits
//   dout      read data
//   busy      pending flag for ra
// ---------------------------------------------------------------------------
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW,
   parameter int ENTRY   = DEF_ENTRY,
   parameter int ZERO_R0 = 1
) (
`ifdef REGFILE_BYPASS_EN
   input  logic             wen0_n,
   input  logic [AW-1:0]    wa0,
   input  logic [DW-1:0]    di0,
   input  logic             wen1_n,
   input  logic [AW-1:0]    wa1,
   input  logic [DW-1:0]    di1,
`endif
   input  logic [AW-1:0]    ra,
   input  logic [DW-1:0]    mem [ENTRY],
   input  logic [ENTRY-1:0] busy_vec,
   output logic [DW-1:0]    dout,
   output logic             busy
);

   logic valid;
`ifdef REGFILE_BYPASS_EN
   wr_sel_t byp;
`endif

   always_comb begin
      valid = (32'(ra) < ENTRY) && !((ZERO_R0 != 0) && (ra == '0));
      dout  = '0;
      busy  = 1'b0;
      if (valid) begin
         dout = mem[ra];
         busy = busy_vec[ra];
      end
`ifdef REGFILE_BYPASS_EN
      // A same-cycle write to ra forwards its data and hides the busy bit
      // it is about to clear. Masked addresses are never written, so the
      // bypass is gated by valid as well.
      byp = wr_resolve(wen0_n, wa0 == ra, wen1_n, wa1 == ra);
      if (valid && byp.hit) begin
         dout = byp.sel1 ? di1 : di0;
         busy = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// ENTRY x DW register file with two prioritised synchronous write ports,
// NRD asynchronous read ports and a per-entry busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// Ports:
//   CLK  clock, all state updates on the rising edge
//   RST  asynchronous active-high reset (array and busy bits to 0)
//   bus  regfile_sb_if slave modport (write ports, read ports, issue, busy)
// ---------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW,
   parameter int ENTRY   = DEF_ENTRY,
   parameter int NRD     = 2,
   parameter int ZERO_R0 = 1
) (
   input logic         CLK,
   input logic         RST,
   regfile_sb_if.slave bus
);

   logic [DW-1:0]    mem_q [ENTRY];
   logic [DW-1:0]    mem_d [ENTRY];
   logic [ENTRY-1:0] busy_q;
   logic [ENTRY-1:0] busy_d;
   wr_sel_t          wsel;

   // Next state: a write clears the busy bit, an issue in the same cycle
   // sets it again because the newer producer wins. Addresses >= ENTRY
   // never match an entry and therefore fall out naturally.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      wsel   = '0;
      for (int e = 0; e < ENTRY; e++) begin
         if (!((ZERO_R0 != 0) && (e == 0))) begin
            wsel = wr_resolve(bus.WEN0, bus.WA0 == AW'(e), bus.WEN1, bus.WA1 == AW'(e));
            if (wsel.hit) begin
               mem_d[e]  = wsel.sel1 ? bus.DI1 : bus.DI0;
               busy_d[e] = 1'b0;
            end
            if (bus.ISSUE && (bus.IWA == AW'(e))) begin
               busy_d[e] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int e = 0; e < ENTRY; e++) begin
            mem_q[e] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   assign bus.ANY_BUSY = |busy_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra_k;
      logic [DW-1:0] dout_k;
      logic          busy_k;

      assign ra_k = AW'(ra_field(RA_FLAT_W'(bus.RA), k, AW));

      regfile_rdport #(
         .DW      (DW),
         .AW      (AW),
         .ENTRY   (ENTRY),
         .ZERO_R0 (ZERO_R0)
      ) u_rdport (
`ifdef REGFILE_BYPASS_EN
         .wen0_n   (bus.WEN0),
         .wa0      (bus.WA0),
         .di0      (bus.DI0),
         .wen1_n   (bus.WEN1),
         .wa1      (bus.WA1),
         .di1      (bus.DI1),
`endif
         .ra       (ra_k),
         .mem      (mem_q),
         .busy_vec (busy_q),
         .dout     (dout_k),
         .busy     (busy_k)
      );

      assign bus.DOUT[k*DW +: DW] = dout_k;
      assign bus.BUSY[k]          = busy_k;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb (ENTRY=24 so that addresses 24..31 are
// out of range, ZERO_R0=1, two read ports). Expectations follow the build:
// with REGFILE_BYPASS_EN defined the same-cycle columns use bypass values.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int ENTRY = 24;
   localparam int NRD   = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        wen0;
      logic [4:0]  wa0;
      logic [31:0] di0;
      logic        wen1;
      logic [4:0]  wa1;
      logic [31:0] di1;
      logic        issue;
      logic [4:0]  iwa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [1:0]  e_busy;
      logic        e_any;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  b;
      logic        a;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) bif ();

   regfile_sb #(
      .DW      (DW),
      .AW      (AW),
      .ENTRY   (ENTRY),
      .NRD     (NRD),
      .ZERO_R0 (1)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bif)
   );

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs [15];
   exp_t sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic is, input logic [4:0] ia,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [31:0] ed0, input logic [31:0] ed1,
                               input logic [1:0] eb, input logic ea);
      vec_t v;
      v.wen0 = w0; v.wa0 = a0; v.di0 = d0;
      v.wen1 = w1; v.wa1 = a1; v.di1 = d1;
      v.issue = is; v.iwa = ia; v.ra0 = r0; v.ra1 = r1;
      v.e_d0 = ed0; v.e_d1 = ed1; v.e_busy = eb; v.e_any = ea;
      return v;
   endfunction

   function automatic vec_t idle(input logic [4:0] r0, input logic [4:0] r1,
                                 input logic [31:0] ed0, input logic [31:0] ed1,
                                 input logic [1:0] eb, input logic ea);
      return mk(1, 0, 0, 1, 0, 0, 0, 0, r0, r1, ed0, ed1, eb, ea);
   endfunction

   task automatic drive(input vec_t v);
      bif.WEN0  = v.wen0; bif.WA0 = v.wa0; bif.DI0 = v.di0;
      bif.WEN1  = v.wen1; bif.WA1 = v.wa1; bif.DI1 = v.di1;
      bif.ISSUE = v.issue; bif.IWA = v.iwa;
      bif.RA    = {v.ra1, v.ra0};
   endtask

   task automatic go_idle();
      bif.WEN0 = 1'b1; bif.WEN1 = 1'b1; bif.ISSUE = 1'b0;
   endtask

   initial begin
      exp_t e;

      // Expected values are the outputs seen during the cycle the vector is
      // applied, i.e. before the edge that commits its writes/issue.
      vecs[0]  = mk(0, 3, 32'h11, 0, 3, 32'h22, 0, 0, 3, 0,
                    BYP ? 32'h22 : 32'h0, 32'h0, 2'b00, 0);
      vecs[1]  = mk(1, 0, 0, 1, 0, 0, 1, 9, 3, 9, 32'h22, 32'h0, 2'b00, 0);
      vecs[2]  = idle(9, 3, 32'h0, 32'h22, 2'b01, 1);
      vecs[3]  = mk(0, 9, 32'h55, 1, 0, 0, 0, 0, 9, 9,
                    BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, BYP ? 2'b00 : 2'b11, 1);
      vecs[4]  = idle(9, 9, 32'h55, 32'h55, 2'b00, 0);
      vecs[5]  = mk(0, 4, 32'h44, 1, 0, 0, 1, 4, 4, 31,
                    BYP ? 32'h44 : 32'h0, 32'h0, 2'b00, 0);
      vecs[6]  = idle(4, 0, 32'h44, 32'h0, 2'b01, 1);
      vecs[7]  = mk(0, 0, 32'h1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 32'h0, 2'b00, 1);
      vecs[8]  = idle(0, 4, 32'h0, 32'h44, 2'b10, 1);
      vecs[9]  = mk(0, 12, 32'hA5A5_A5A5, 1, 0, 0, 0, 0, 12, 4,
                    BYP ? 32'hA5A5_A5A5 : 32'h0, 32'h44, 2'b10, 1);
      vecs[10] = idle(12, 4, 32'hA5A5_A5A5, 32'h44, 2'b10, 1);
      vecs[11] = mk(0, 4, 32'h77, 0, 4, 32'h66, 0, 0, 4, 12,
                    BYP ? 32'h66 : 32'h44, 32'hA5A5_A5A5, BYP ? 2'b00 : 2'b01, 1);
      vecs[12] = idle(4, 12, 32'h66, 32'hA5A5_A5A5, 2'b00, 0);
      vecs[13] = mk(0, 23, 32'h2323, 0, 30, 32'h99, 1, 30, 23, 30,
                    BYP ? 32'h2323 : 32'h0, 32'h0, 2'b00, 0);
      vecs[14] = idle(23, 30, 32'h2323, 32'h0, 2'b00, 0);

      // Reset state
      rst = 1'b1;
      go_idle();
      bif.WA0 = '0; bif.DI0 = '0; bif.WA1 = '0; bif.DI1 = '0; bif.IWA = '0;
      bif.RA  = {5'd3, 5'd1};
      #8;
      chk("reset.dout", bif.DOUT, 64'h0);
      chk("reset.busy", 32'(bif.BUSY), 32'h0);
      chk("reset.any", 32'(bif.ANY_BUSY), 32'h0);
      #4 rst = 1'b0;

      // Table-driven vectors through the scoreboard queue
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         drive(vecs[i]);
         sb_q.push_back('{i, vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_busy, vecs[i].e_any});
         @(negedge clk);
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries, expected 1");
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d.dout0", e.idx), bif.DOUT[31:0], e.d0);
            chk($sformatf("v%0d.dout1", e.idx), bif.DOUT[63:32], e.d1);
            chk($sformatf("v%0d.busy", e.idx), 32'(bif.BUSY), 32'(e.b));
            chk($sformatf("v%0d.any", e.idx), 32'(bif.ANY_BUSY), 32'(e.a));
         end
      end

      // Mid-cycle asynchronous reset with a write in flight
      @(posedge clk);
      #1;
      go_idle();
      bif.WEN0 = 1'b0; bif.WA0 = 5'd5; bif.DI0 = 32'hDEAD_BEEF;
      bif.ISSUE = 1'b1; bif.IWA = 5'd7;
      @(posedge clk);
      #1;
      go_idle();
      bif.RA = {5'd7, 5'd5};
      @(negedge clk);
      chk("pre_rst.dout0", bif.DOUT[31:0], 32'hDEAD_BEEF);
      chk("pre_rst.busy", 32'(bif.BUSY), 32'h2);
      chk("pre_rst.any", 32'(bif.ANY_BUSY), 32'h1);
      #1;
      bif.WEN0 = 1'b0; bif.WA0 = 5'd5; bif.DI0 = 32'h1234;
      rst = 1'b1;
      #1;
      chk("rst_async.dout0", bif.DOUT[31:0], 32'h0);
      chk("rst_async.busy", 32'(bif.BUSY), 32'h0);
      chk("rst_async.any", 32'(bif.ANY_BUSY), 32'h0);
      @(posedge clk);
      #1;
      go_idle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst.dout0", bif.DOUT[31:0], 32'h0);
      chk("post_rst.dout1", bif.DOUT[63:32], 32'h0);
      chk("post_rst.any", 32'(bif.ANY_BUSY), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
